mix_columns_seq: RTL and testbench

//  - Time-multiplexed sequencer for the AES MixColumns step. Accepts one 4x4 byte state

---
 rtl/aes_pkg.sv | 25 ++
 rtl/mixColumns_col.sv | 23 ++
 rtl/mix_columns_seq.sv | 127 ++++++++++++
 tb/tb_mix_columns_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES datapath types and the MixColumns sequencer FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [7:0]       byte_t;
    typedef byte_t [3:0]      column_t;   // [row]
    typedef byte_t [3:0][3:0] state_t;    // [row][col]

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mixseq_state_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mixColumns_col.sv
`default_nettype none
// ============================================================================
// Module   : mixColumns_col
// Brief    : AES MixColumns on a single 4-byte column (pure combinational).
// Revision : 1.0 - initial release
// ============================================================================
module mixColumns_col
    import aes_pkg::*;
(
    input  column_t in_col,
    output column_t out_col
);

    // b[r] = 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3], row indices modulo 4.
    for (genvar r = 0; r < 4; r++) begin : g_row
        assign out_col[r] = xtime(in_col[r])
                          ^ xtime(in_col[(r + 1) % 4]) ^ in_col[(r + 1) % 4]
                          ^ in_col[(r + 2) % 4]
                          ^ in_col[(r + 3) % 4];
    end

endmodule
`default_nettype wire

// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module   : mix_columns_seq
// Brief    : Time-multiplexed AES MixColumns. Accepts a 4x4 state, mixes
//            COLS_PER_CYCLE columns per cycle through shared mixColumns_col
//            instances and returns the result over a valid/ready handshake.
//            Optional macro MIXCOL_BYPASS_EN adds in_bypass (final-round skip).
// Revision : 1.0 - initial release
// ============================================================================
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0][3:0][7:0] in_state,
`ifdef MIXCOL_BYPASS_EN
    input  logic                 in_bypass,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0][3:0][7:0] out_state,
    output logic                 busy
);

    localparam int NGROUPS = 4 / COLS_PER_CYCLE;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mixseq_state_e r_state;
    mixseq_state_e w_state_nxt;
    logic [1:0]    r_col_idx;
    state_t        r_work;
    state_t        w_work_mixed;
    logic          w_accept;
    logic          w_bypass;
    logic          w_last_group;

    logic    [COLS_PER_CYCLE-1:0][1:0] w_col_sel;
    column_t [COLS_PER_CYCLE-1:0]      w_mix_in;
    column_t [COLS_PER_CYCLE-1:0]      w_mix_out;

`ifdef MIXCOL_BYPASS_EN
    assign w_bypass = in_bypass;
`else
    assign w_bypass = 1'b0;
`endif

    assign in_ready     = (r_state == IDLE) && rst_n;
    assign out_valid    = (r_state == DONE);
    assign busy         = (r_state != IDLE);
    assign out_state    = r_work;
    assign w_accept     = in_valid && in_ready;
    assign w_last_group = (r_col_idx == 2'(NGROUPS - 1));

    // Each shared mixer k works on column col_idx*COLS_PER_CYCLE+k.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_mixer
        assign w_col_sel[k] = 2'(int'(r_col_idx) * COLS_PER_CYCLE + k);
        for (genvar r = 0; r < 4; r++) begin : g_sel_row
            assign w_mix_in[k][r] = r_work[r][w_col_sel[k]];
        end
        mixColumns_col u_mix (
            .in_col  (w_mix_in[k]),
            .out_col (w_mix_out[k])
        );
    end

    // Write mixed columns back in place; unaddressed columns keep their bytes.
    always_comb begin
        w_work_mixed = r_work;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            for (int r = 0; r < 4; r++) begin
                w_work_mixed[r][w_col_sel[k]] = w_mix_out[k][r];
            end
        end
    end

    // Next-state logic: accept in IDLE, walk column groups in BUSY, hold in DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_bypass ? DONE : BUSY;
            BUSY: if (w_last_group) w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Work register and group counter: capture on accept, update in place while BUSY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_work    <= '0;
            r_col_idx <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_work    <= in_state;
                        r_col_idx <= 2'd0;
                    end
                end
                BUSY: begin
                    r_work    <= w_work_mixed;
                    r_col_idx <= w_last_group ? 2'd0 : r_col_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mix_columns_seq
// Brief    : Self-checking bench for mix_columns_seq with COLS_PER_CYCLE = 1,
//            2 and 4 side by side; scoreboard against a GF(2^8) matrix model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mix_columns_seq;
    import aes_pkg::*;

    localparam int NI = 3;

    typedef struct {
        state_t exp;
        int     acc;
        int     lat;
    } exp_t;

    logic   clk = 1'b0;
    always #5 clk = ~clk;

    logic   rst_n     [NI];
    logic   in_valid  [NI];
    logic   in_ready  [NI];
    logic   in_bypass [NI];
    logic   out_valid [NI];
    logic   out_ready [NI];
    logic   busy      [NI];
    state_t in_state  [NI];
    state_t out_state [NI];
    logic   dir_valid [NI];
    state_t dir_exp   [NI];
    logic   b2b       [NI];
    int     pend      [NI];
    int     acc_cnt   [NI];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int inst,
                         input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [N=%0d] t=%0t actual=%h required=%h", name, 1 << inst, $time, act, exp);
        end
    endtask

    task automatic fail_to(input string name, input int inst);
        checks++;
        errors++;
        $display("FAIL %s [N=%0d] t=%0t actual=timeout required=event", name, 1 << inst, $time);
    endtask

    // GF(2^8) product by shift-and-add with reduction by 0x11b.
    function automatic byte_t gmul(input byte_t a, input byte_t b);
        int p = 0;
        int x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
        end
        return byte_t'(p);
    endfunction

    // Circulant matrix (2 3 1 1) times each column.
    function automatic state_t mix_ref(input state_t s);
        byte_t  coef [4] = '{8'd2, 8'd3, 8'd1, 8'd1};
        state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[r][c] = 8'h00;
                for (int j = 0; j < 4; j++) o[r][c] = o[r][c] ^ gmul(coef[(j - r + 4) % 4], s[j][c]);
            end
        end
        return o;
    endfunction

    // Each word is one column, row 0 in the top byte.
    function automatic state_t from_cols(input logic [31:0] c0, input logic [31:0] c1,
                                         input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0] w [4];
        state_t      s;
        w[0] = c0; w[1] = c1; w[2] = c2; w[3] = c3;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = w[c][31 - 8 * r -: 8];
        return s;
    endfunction

    function automatic state_t rnd_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_bench
        localparam int N  = 1 << g;
        localparam int NG = 4 / N;

        exp_t   q [$];
        logic   prev_ov  = 1'b0;
        logic   prev_or  = 1'b0;
        logic   prev_rst = 1'b0;
        state_t prev_os  = '0;
        int     last_acc = -1;

        mix_columns_seq #(.COLS_PER_CYCLE(N)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
`ifdef MIXCOL_BYPASS_EN
            .in_bypass (in_bypass[g]),
`endif
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );

        // Scoreboard monitor: push on accept, pop and compare on output handshake.
        always @(negedge clk) begin
            state_t e;
            logic   byp;
            if (!prev_rst) begin
                check("rst_out_valid", g, out_valid[g], 1'b0);
                check("rst_busy", g, busy[g], 1'b0);
                check("rst_out_state", g, out_state[g], '0);
                check("rst_in_ready", g, in_ready[g], rst_n[g]);
            end
            if (!rst_n[g]) begin
                check("in_ready_in_reset", g, in_ready[g], 1'b0);
                q.delete();
                last_acc = -1;
            end else begin
                if (in_valid[g] && in_ready[g]) begin
`ifdef MIXCOL_BYPASS_EN
                    byp = in_bypass[g];
`else
                    byp = 1'b0;
`endif
                    e = dir_valid[g] ? dir_exp[g] : (byp ? in_state[g] : mix_ref(in_state[g]));
                    q.push_back('{e, cyc + 1, byp ? 1 : NG});
                    acc_cnt[g] = acc_cnt[g] + 1;
                    if (b2b[g] && last_acc >= 0) check("b2b_spacing", g, cyc + 1 - last_acc, NG + 2);
                    last_acc = cyc + 1;
                end
                if (!b2b[g]) last_acc = -1;
                if (out_valid[g] && !prev_ov) begin
                    if (q.size() == 0) check("spurious_out_valid", g, out_valid[g], 1'b0);
                    else check("latency", g, cyc - q[0].acc, q[0].lat);
                end
                if (prev_ov && !prev_or && prev_rst) begin
                    check("hold_out_valid", g, out_valid[g], 1'b1);
                    check("hold_out_state", g, out_state[g], prev_os);
                end
                if (out_valid[g]) check("in_ready_while_done", g, in_ready[g], 1'b0);
                if (out_valid[g] && out_ready[g]) begin
                    if (q.size() == 0) check("unexpected_output", g, out_valid[g], 1'b0);
                    else begin
                        check("out_state", g, out_state[g], q[0].exp);
                        void'(q.pop_front());
                    end
                end
            end
            pend[g]  = q.size();
            prev_ov  = out_valid[g];
            prev_or  = out_ready[g];
            prev_rst = rst_n[g];
            prev_os  = out_state[g];
        end
    end

    task automatic send(input int i, input state_t s, input logic byp);
        int n = 0;
        in_valid[i]  = 1'b1;
        in_state[i]  = s;
        in_bypass[i] = byp;
        @(negedge clk); #1;
        while (!in_ready[i] && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready[i]) fail_to("send_accept", i);
        @(posedge clk); #1;
        in_valid[i]  = 1'b0;
        in_state[i]  = rnd_state();
        in_bypass[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        @(negedge clk); #1;
        while ((pend[i] != 0 || out_valid[i] || !in_ready[i]) && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 300) fail_to("wait_idle", i);
        @(posedge clk); #1;
    endtask

    task automatic directed(input int i, input state_t s, input state_t e, input logic byp);
        dir_exp[i]   = e;
        dir_valid[i] = 1'b1;
        send(i, s, byp);
        dir_valid[i] = 1'b0;
    endtask

    task automatic run(input int i);
        int     n;
        int     start;
        state_t s1, e1, s2, e2, s4, e4;
        s1 = from_cols(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345);
        e1 = from_cols(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc);
        s2 = from_cols(32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5);
        e2 = from_cols(32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6);
        s4 = from_cols(32'h2d26314c, 32'h2d26314c, 32'h2d26314c, 32'h2d26314c);
        e4 = from_cols(32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8);

        rst_n[i]     = 1'b0;
        in_valid[i]  = 1'b0;
        in_state[i]  = '0;
        in_bypass[i] = 1'b0;
        out_ready[i] = 1'b1;
        dir_valid[i] = 1'b0;
        dir_exp[i]   = '0;
        b2b[i]       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n[i] = 1'b1;

        // Uniform columns, then distinct columns.
        directed(i, s1, e1, 1'b0);
        wait_idle(i);
        directed(i, s2, e2, 1'b0);
        wait_idle(i);

        // Backpressure in DONE.
        out_ready[i] = 1'b0;
        directed(i, s2, e2, 1'b0);
        n = 0;
        @(negedge clk); #1;
        while (!out_valid[i] && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!out_valid[i]) fail_to("bp_out_valid", i);
        repeat (10) @(posedge clk);
        #1 out_ready[i] = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        check("bp_in_ready_after", i, in_ready[i], 1'b1);
        check("bp_out_valid_after", i, out_valid[i], 1'b0);
        @(posedge clk); #1;

        // Back-to-back with in_valid held high.
        dir_exp[i]   = e4;
        dir_valid[i] = 1'b1;
        b2b[i]       = 1'b1;
        in_state[i]  = s4;
        in_valid[i]  = 1'b1;
        start        = acc_cnt[i];
        n            = 0;
        while (acc_cnt[i] < start + 4 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (acc_cnt[i] < start + 4) fail_to("b2b_accepts", i);
        @(posedge clk); #1;
        in_valid[i]  = 1'b0;
        b2b[i]       = 1'b0;
        dir_valid[i] = 1'b0;
        wait_idle(i);

        // Reset two edges into an operation; nothing may be emitted.
        out_ready[i] = 1'b0;
        send(i, s1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n[i] = 1'b0;
        @(posedge clk);
        #1 rst_n[i] = 1'b1;
        repeat (8) @(posedge clk);
        #1 out_ready[i] = 1'b1;
        wait_idle(i);
        directed(i, s1, e1, 1'b0);
        wait_idle(i);

        // Random traffic with random backpressure.
        for (int c = 0; c < 300; c++) begin
            in_valid[i]  = 1'($urandom_range(0, 1));
            in_state[i]  = rnd_state();
`ifdef MIXCOL_BYPASS_EN
            in_bypass[i] = 1'($urandom_range(0, 1));
`endif
            out_ready[i] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid[i]  = 1'b0;
        in_bypass[i] = 1'b0;
        out_ready[i] = 1'b1;
        wait_idle(i);

`ifdef MIXCOL_BYPASS_EN
        directed(i, s1, s1, 1'b1);
        wait_idle(i);
        directed(i, s1, e1, 1'b0);
        wait_idle(i);
`endif
    endtask

    initial begin
        fork
            run(0);
            run(1);
            run(2);
        join
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
